cpu_bmem_ctrl: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/line_assembler.sv | 40 ++++
 rtl/cpu_bmem_ctrl.sv | 130 +++++++++++++
 tb/tb_cpu_bmem_ctrl.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the cpu memory-side blocks: line/beat geometry,
// the banked-memory controller state machine and the cache-client owner tag.
package cpu_types_pkg;

  localparam int LINE_BITS = 256;
  localparam int BEAT_BITS = 64;
  localparam int BURST_LEN = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_BURST,
    RESP
  } bmem_state_t;

  typedef enum logic {
    ICACHE,
    DCACHE
  } bmem_client_t;

  // Memory is addressed in whole 32-byte lines.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & ~32'h0000_001F;
  endfunction

endpackage

// File: rtl/line_assembler.sv
// Collects BURST_LEN read beats into one cache line in arrival order; line_nxt
// and done expose the line including the beat accepted this cycle.
module line_assembler
  import cpu_types_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 beat_vld,
  input  logic [BEAT_BITS-1:0] beat_data,
  output logic [LINE_BITS-1:0] line_nxt,
  output logic                 done
);

  logic [1:0]           cnt_q, cnt_d;
  logic [LINE_BITS-1:0] line_q, line_d;

  always_comb begin
    cnt_d  = cnt_q;
    line_d = line_q;
    done   = 1'b0;
    if (clr) begin
      cnt_d  = '0;
      line_d = '0;
    end else if (beat_vld) begin
      line_d[int'(cnt_q)*BEAT_BITS +: BEAT_BITS] = beat_data;
      cnt_d = cnt_q + 2'd1;
      done  = (int'(cnt_q) == BURST_LEN - 1);
    end
  end

  assign line_nxt = line_d;

  always_ff @(posedge clk) begin
    line_q <= line_d;
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cpu_bmem_ctrl.sv
// Merges icache and dcache line requests onto the single banked-memory port,
// one transaction at a time, dcache winning ties.
module cpu_bmem_ctrl
  import cpu_types_pkg::*;
#(
  parameter int SS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          i_addr,
  input  logic                 i_read,
  output logic [LINE_BITS-1:0] i_rdata,
  output logic                 i_resp,
  input  logic [31:0]          d_addr,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [LINE_BITS-1:0] d_wdata,
  output logic [LINE_BITS-1:0] d_rdata,
  output logic                 d_resp,
  output logic [31:0]          bmem_addr,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [BEAT_BITS-1:0] bmem_wdata,
  input  logic                 bmem_ready,
  input  logic [31:0]          bmem_raddr,
  input  logic [BEAT_BITS-1:0] bmem_rdata,
  input  logic                 bmem_rvalid
);

  if (SS < 1) begin : g_ss_invalid
  end

  bmem_state_t          state_q, state_d;
  bmem_client_t         owner_q, owner_d;
  logic [31:0]          addr_q, addr_d;
  logic [LINE_BITS-1:0] wline_q, wline_d;
  logic [1:0]           wcnt_q, wcnt_d;
  logic [LINE_BITS-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_BITS-1:0] d_rdata_q, d_rdata_d;

  logic                 beat_take;
  logic [LINE_BITS-1:0] asm_line;
  logic                 asm_done;

  // Beats tagged for any other line belong to someone else and are dropped.
  assign beat_take = (state_q == RD_WAIT) && bmem_rvalid && (bmem_raddr == addr_q);

  line_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_q != RD_WAIT),
    .beat_vld  (beat_take),
    .beat_data (bmem_rdata),
    .line_nxt  (asm_line),
    .done      (asm_done)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wline_d   = wline_q;
    wcnt_d    = wcnt_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        wcnt_d = '0;
        if (d_read || d_write) begin
          owner_d = DCACHE;
          addr_d  = line_align(d_addr);
          wline_d = d_wdata;
          state_d = d_write ? WR_BURST : RD_ISSUE;
        end else if (i_read) begin
          owner_d = ICACHE;
          addr_d  = line_align(i_addr);
          state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        if (bmem_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (asm_done) begin
          state_d = RESP;
          if (owner_q == ICACHE) i_rdata_d = asm_line;
          else                   d_rdata_d = asm_line;
        end
      end
      WR_BURST: begin
        if (bmem_ready) begin
          wcnt_d = wcnt_q + 2'd1;
          if (int'(wcnt_q) == BURST_LEN - 1) state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    wline_q <= wline_d;
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= ICACHE;
      addr_q    <= '0;
      wcnt_q    <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wcnt_q    <= wcnt_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Memory-side outputs come only from registered state.
  assign bmem_addr  = addr_q;
  assign bmem_read  = (state_q == RD_ISSUE);
  assign bmem_write = (state_q == WR_BURST);
  assign bmem_wdata = bmem_write ? wline_q[int'(wcnt_q)*BEAT_BITS +: BEAT_BITS] : '0;
  assign i_resp     = (state_q == RESP) && (owner_q == ICACHE);
  assign d_resp     = (state_q == RESP) && (owner_q == DCACHE);
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_cpu_bmem_ctrl.sv
// Scoreboard bench for cpu_bmem_ctrl: a small banked-memory model serves read
// bursts, expected lines and write beats are queued when requests are driven.
module tb_cpu_bmem_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_addr;
  logic         i_read;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic [31:0]  d_addr;
  logic         d_read;
  logic         d_write;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  cpu_bmem_ctrl #(.SS(1)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_d;
    logic [255:0] line;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] wbeat_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  int i_resp_cnt = 0;
  int d_resp_cnt = 0;

  int          beats_left;
  logic [31:0] cur_addr;
  bit          junk_tog;
  logic [63:0] seed;

  always @(negedge clk) begin
    if (i_resp) i_resp_cnt <= i_resp_cnt + 1;
    if (d_resp) d_resp_cnt <= d_resp_cnt + 1;
  end

  function automatic logic [63:0] mem_beat(input logic [31:0] a, input int k, input logic [63:0] s);
    logic [7:0] b;
    b = 8'(8'h11 * (k + 1));
    return {8{b}} ^ {a, a} ^ s;
  endfunction

  function automatic logic [255:0] exp_line(input logic [31:0] a, input logic [63:0] s);
    logic [255:0] l;
    for (int k = 0; k < 4; k++) l[k*64 +: 64] = mem_beat(a, k, s);
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Memory model: drives this cycle's return beat, then latches an accepted command.
  task automatic serve_cycle(input bit junk);
    if (beats_left > 0) begin
      bmem_rvalid = 1'b1;
      if (junk && junk_tog) begin
        bmem_raddr = 32'hDEAD_0000;
        bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        junk_tog   = 1'b0;
      end else begin
        bmem_raddr = cur_addr;
        bmem_rdata = mem_beat(cur_addr, 4 - beats_left, seed);
        beats_left--;
        junk_tog   = 1'b1;
      end
    end else begin
      bmem_rvalid = 1'b0;
      bmem_raddr  = 32'h0;
      bmem_rdata  = 64'h0;
    end
    if (bmem_read && bmem_ready) begin
      cur_addr   = bmem_addr;
      beats_left = 4;
    end
  endtask

  task automatic idle_inputs();
    i_read = 0; d_read = 0; d_write = 0;
    bmem_ready = 1; bmem_rvalid = 0; bmem_raddr = 0; bmem_rdata = 0;
    beats_left = 0; junk_tog = 1'b1;
  endtask

  task automatic test_reset();
    i_addr = 32'h0000_1004; d_addr = 32'h0000_2008; d_wdata = '0;
    idle_inputs();
    i_read = 1; d_read = 1; bmem_ready = 0;
    rst = 1;
    for (int r = 0; r < 2; r++) begin
      step();
      n_cmp++;
      if ({bmem_read, bmem_write, i_resp, d_resp, bmem_addr, bmem_wdata, i_rdata, d_rdata} !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs cycle=%0d read=%b write=%b i_resp=%b d_resp=%b addr=%h wdata=%h expected all 0",
                 r, bmem_read, bmem_write, i_resp, d_resp, bmem_addr, bmem_wdata);
      end
    end
    rst = 0;
    n_cmp++;
    if (bmem_read !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_idle bmem_read=%b expected 0", bmem_read);
    end
    step();
    n_cmp++;
    if (bmem_read !== 1'b1 || bmem_addr !== 32'h0000_2000) begin
      n_bad++;
      $display("FAIL reset_first_issue read=%b addr=%h expected read=1 addr=00002000", bmem_read, bmem_addr);
    end
    rst = 1; i_read = 0; d_read = 0;
    step();
    rst = 0;
    step();
    n_cmp++;
    if (bmem_read !== 1'b0 || bmem_write !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_abort_issue read=%b write=%b expected 0 0", bmem_read, bmem_write);
    end
  endtask

  task automatic test_icache_read();
    int issue_cyc = -1, resp_cyc = -1, ic0;
    exp_t e;
    idle_inputs();
    seed = {2{32'h1000_0020}};
    ic0 = i_resp_cnt;
    i_addr = 32'h1000_0024; i_read = 1;
    exp_q.push_back('{1'b0, exp_line(32'h1000_0020, seed)});
    cyc = 0;
    repeat (20) begin
      step();
      serve_cycle(1'b0);
      if (bmem_read && issue_cyc < 0) begin
        issue_cyc = cyc;
        n_cmp++;
        if (bmem_addr !== 32'h1000_0020) begin
          n_bad++;
          $display("FAIL icache_addr got=%h expected=10000020", bmem_addr);
        end
      end
      if (i_resp) begin
        resp_cyc = cyc;
        i_read = 0;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL icache_extra_resp cycle=%0d no response expected", cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.is_d !== 1'b0 || i_rdata !== e.line) begin
            n_bad++;
            $display("FAIL icache_rdata got=%h expected=%h", i_rdata, e.line);
          end
        end
      end
    end
    n_cmp++;
    if (issue_cyc !== 1 || resp_cyc !== 6) begin
      n_bad++;
      $display("FAIL icache_timing issue=%0d resp=%0d expected issue=1 resp=6", issue_cyc, resp_cyc);
    end
    n_cmp++;
    if (i_resp_cnt - ic0 !== 1) begin
      n_bad++;
      $display("FAIL icache_resp_count got=%0d expected=1", i_resp_cnt - ic0);
    end
  endtask

  task automatic test_dcache_write();
    int accepted = 0, last_acc = -1, resp_cyc = -1, dc0;
    logic [63:0] b;
    idle_inputs();
    dc0 = d_resp_cnt;
    d_addr = 32'h2000_0040;
    d_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 4; k++) begin
      b = d_wdata[k*64 +: 64];
      wbeat_q.push_back(b);
    end
    d_write = 1;
    cyc = 0;
    repeat (25) begin
      step();
      bmem_ready = (cyc % 2 == 0);
      if (bmem_write) begin
        n_cmp++;
        if (wbeat_q.size() == 0) begin
          n_bad++;
          $display("FAIL write_extra_beat cycle=%0d wdata=%h expected no beat", cyc, bmem_wdata);
        end else if (bmem_wdata !== wbeat_q[0] || bmem_addr !== 32'h2000_0040) begin
          n_bad++;
          $display("FAIL write_beat%0d wdata=%h addr=%h expected wdata=%h addr=20000040",
                   accepted, bmem_wdata, bmem_addr, wbeat_q[0]);
        end
        if (bmem_ready && wbeat_q.size() > 0) begin
          void'(wbeat_q.pop_front());
          accepted++;
          last_acc = cyc;
        end
      end
      if (d_resp) begin
        resp_cyc = cyc;
        d_write = 0;
      end
    end
    bmem_ready = 1;
    n_cmp++;
    if (accepted !== 4 || resp_cyc !== last_acc + 1) begin
      n_bad++;
      $display("FAIL write_completion accepted=%0d resp_cyc=%0d expected 4 beats and resp at %0d",
               accepted, resp_cyc, last_acc + 1);
    end
    n_cmp++;
    if (d_resp_cnt - dc0 !== 1) begin
      n_bad++;
      $display("FAIL write_resp_count got=%0d expected=1", d_resp_cnt - dc0);
    end
  endtask

  task automatic test_back_to_back();
    int n_issue = 0, d_resp_cyc = -1, i_issue_cyc = -1, ic0, dc0;
    exp_t e;
    idle_inputs();
    seed = 64'h0123_4567_89AB_CDEF;
    ic0 = i_resp_cnt; dc0 = d_resp_cnt;
    i_addr = 32'h5000_0000; d_addr = 32'h6000_0010;
    exp_q.push_back('{1'b1, exp_line(32'h6000_0000, seed)});
    exp_q.push_back('{1'b0, exp_line(32'h5000_0000, seed)});
    i_read = 1; d_read = 1;
    cyc = 0;
    repeat (30) begin
      step();
      if (bmem_read && bmem_ready) begin
        n_issue++;
        n_cmp++;
        if (bmem_addr !== (n_issue == 1 ? 32'h6000_0000 : 32'h5000_0000)) begin
          n_bad++;
          $display("FAIL arb_issue%0d addr=%h expected=%h", n_issue, bmem_addr,
                   (n_issue == 1 ? 32'h6000_0000 : 32'h5000_0000));
        end
        if (n_issue == 2) i_issue_cyc = cyc;
      end
      serve_cycle(1'b0);
      if (d_resp || i_resp) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL arb_extra_resp i_resp=%b d_resp=%b no response expected", i_resp, d_resp);
        end else begin
          e = exp_q.pop_front();
          if (e.is_d !== d_resp || e.is_d === i_resp || (d_resp ? d_rdata : i_rdata) !== e.line) begin
            n_bad++;
            $display("FAIL arb_resp i_resp=%b d_resp=%b line=%h expected dcache=%b line=%h",
                     i_resp, d_resp, (d_resp ? d_rdata : i_rdata), e.is_d, e.line);
          end
        end
        if (d_resp) begin d_read = 0; d_resp_cyc = cyc; end
        if (i_resp) i_read = 0;
      end
    end
    n_cmp++;
    if (n_issue !== 2 || i_issue_cyc !== d_resp_cyc + 2) begin
      n_bad++;
      $display("FAIL arb_order issues=%0d icache_issue=%0d expected 2 issues, icache at %0d",
               n_issue, i_issue_cyc, d_resp_cyc + 2);
    end
    n_cmp++;
    if (i_resp_cnt - ic0 !== 1 || d_resp_cnt - dc0 !== 1 || exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL arb_resp_counts i=%0d d=%0d left=%0d expected 1 1 0",
               i_resp_cnt - ic0, d_resp_cnt - dc0, exp_q.size());
    end
  endtask

  task automatic test_tag_filter();
    int rd_cycles = 0, dc0;
    bit got = 0;
    exp_t e;
    idle_inputs();
    seed = 64'hFEDC_BA98_7654_3210;
    dc0 = d_resp_cnt;
    d_addr = 32'h3000_0080; d_read = 1;
    exp_q.push_back('{1'b1, exp_line(32'h3000_0080, seed)});
    cyc = 0;
    repeat (40) begin
      step();
      bmem_ready = (cyc >= 4);
      if (bmem_read) rd_cycles++;
      serve_cycle(1'b1);
      if (d_resp) begin
        got = 1;
        d_read = 0;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL tag_extra_resp cycle=%0d no response expected", cyc);
        end else begin
          e = exp_q.pop_front();
          if (d_rdata !== e.line) begin
            n_bad++;
            $display("FAIL tag_filter_line got=%h expected=%h", d_rdata, e.line);
          end
        end
      end
    end
    bmem_ready = 1;
    n_cmp++;
    if (!got || rd_cycles !== 4 || d_resp_cnt - dc0 !== 1) begin
      n_bad++;
      $display("FAIL tag_filter_flow resp_seen=%0d read_cycles=%0d resps=%0d expected 1 4 1",
               got, rd_cycles, d_resp_cnt - dc0);
    end
  endtask

  task automatic test_reset_mid_read();
    int ic0, guard = 0, rd_seen = 0;
    bit got = 0;
    logic [255:0] prev_line;
    exp_t e;
    idle_inputs();
    seed = 64'hA5A5_5A5A_0F0F_F0F0;
    prev_line = i_rdata;
    ic0 = i_resp_cnt;
    i_addr = 32'h4000_0000; i_read = 1;
    cyc = 0;
    step();
    serve_cycle(1'b0);
    while (beats_left != 2 && guard < 10) begin
      step();
      serve_cycle(1'b0);
      guard++;
    end
    rst = 1;
    step();
    serve_cycle(1'b0);
    rst = 0; i_read = 0;
    repeat (8) begin
      step();
      serve_cycle(1'b0);
      if (bmem_read) rd_seen++;
    end
    n_cmp++;
    if (i_resp_cnt !== ic0 || rd_seen !== 0) begin
      n_bad++;
      $display("FAIL abort_quiet resps=%0d reissues=%0d expected 0 0", i_resp_cnt - ic0, rd_seen);
    end
    n_cmp++;
    if (i_rdata !== '0) begin
      n_bad++;
      $display("FAIL abort_rdata_reset got=%h expected 0 (prev %h)", i_rdata, prev_line);
    end
    seed = 64'h1357_9BDF_2468_ACE0;
    beats_left = 0;
    exp_q.push_back('{1'b0, exp_line(32'h4000_0000, seed)});
    i_read = 1;
    repeat (20) begin
      step();
      serve_cycle(1'b0);
      if (i_resp) begin
        got = 1;
        i_read = 0;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL fresh_extra_resp cycle=%0d no response expected", cyc);
        end else begin
          e = exp_q.pop_front();
          if (i_rdata !== e.line) begin
            n_bad++;
            $display("FAIL fresh_read_line got=%h expected=%h", i_rdata, e.line);
          end
        end
      end
    end
    n_cmp++;
    if (!got || i_resp_cnt - ic0 !== 1) begin
      n_bad++;
      $display("FAIL fresh_read_resp seen=%0d resps=%0d expected 1 1", got, i_resp_cnt - ic0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    idle_inputs();
    i_addr = 0; d_addr = 0; d_wdata = 0; seed = 0; cur_addr = 0; cyc = 0;
    #1;
    test_reset();
    step();
    test_icache_read();
    step();
    test_dcache_write();
    step();
    test_back_to_back();
    step();
    test_tag_filter();
    step();
    test_reset_mid_read();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
